mux81_tdm: RTL and testbench
============================

# mux81_tdm

Time-division 8:1 multiplexer and serializer. It captures an 8-bit parallel word and emits it one bit per cycle on a single line, LSB first. It drives the slot index on `sel` alongside each bit so that the existing combinational 1:8 demux (`in`/`sel`/`out`) can reconstruct the word at the far end. This is the transmit end of the lane-select path, and the sequential counterpart of the demux.

## Interface
- No parameters; the slot count is fixed at 8 and the slot index is 3 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input 8: parallel word; sampled only on a capture edge.
- `start` input 1: request to begin a frame; sampled in IDLE only.
- `cont` input 1: continuous mode; sampled at slot 7.
- `en` input 1: advance enable; low freezes all state.
- `out` output 1: serialized bit equal to `shadow[sel]`.
- `sel` output 3: current slot index, 0..7.
- `valid` output 1: high while `out`/`sel` carry a live slot.
- `frame` output 1: `valid && sel==0`; marks the start of a word.
- `busy` output 1: high in SCAN.
- `done` output 1: one-cycle pulse after the final slot of a frame that ends without `cont`.

## Operation
- State machine IDLE/SCAN, plus an 8-bit `shadow` register and a 3-bit slot counter.
- Outputs decode registered state only. There is no combinational path from `in`, `start`, `cont` or `en` to any output.
- Reset (`rst`=1 at an edge) applies in any state, including mid-frame:
  - state goes to IDLE; `shadow`=0; slot=0;
  - `out`=0, `sel`=0, `valid`=0, `frame`=0, `busy`=0, `done`=0;
  - a frame in progress is abandoned with no `done`.
- `rst` has priority over `en`; `en` has priority over everything else.
- IDLE, `en`=1, `start`=1: `shadow` <= `in`, slot <= 0, go to SCAN.
- IDLE, `start`=0: stay in IDLE; `valid`=0, `out`=0, `sel`=0.
- SCAN, `en`=1, slot<7: slot <= slot+1.
- SCAN, `en`=1, slot==7, `cont`=1:
  - `shadow` <= `in`, slot wraps to 0, stay in SCAN;
  - no idle gap and no `done`.
- SCAN, `en`=1, slot==7, `cont`=0: go to IDLE and assert `done` for exactly one cycle.
- `en`=0 in any state:
  - state, slot, `shadow` and `done` hold;
  - `valid` is forced to 0 for that cycle and `out`/`sel` hold their values;
  - `start` is ignored.
- `start` in SCAN is ignored and is not queued.
- `in` changing mid-frame has no effect on the frame in progress.

## Timing
- Capture on edge N (IDLE, `start`=1, `en`=1): after edge N, `valid`=1, `sel`=0, `out`=`in`[0] as sampled at N.
- Latency from start to first bit: 1 cycle.
- Slot k is presented after edge N+k, for k = 0..7.
- Frame end without `cont`, edge N+8: IDLE, `valid`=0, `busy`=0, `done`=1 for that cycle only.
- The earliest next capture is edge N+9 (`start` sampled while `done`=1 is legal).
- Frame end with `cont`, edge N+8: the new word is captured; `sel`=0 and `frame`=1.
  - Throughput is 8 cycles per word with no gap.
- Each low cycle of `en` extends the frame by exactly one cycle.
- `done` and `frame` are never high in the same cycle.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs -> every output 0. Then `start` with `in`=8'hA5 -> `out` sequence 1,0,1,0,0,1,0,1 on `sel`=0..7, `valid`=1 for 8 cycles, then `done`=1 for one cycle.
- Demux loopback: connect `out`/`sel` to a demux81_comb and latch its outputs on `valid`. For each of 8'h00, 8'hFF, 8'h01, 8'h80 the reconstructed word equals the input.
- Continuous mode: hold `cont`=1, present 8'h3C, then change `in` to 8'hC3 mid-frame -> the first frame is 3C. At slot 7, 8'hC3 is captured; `frame` rises on the very next cycle with no `valid` gap and no `done`.
- Stall: drop `en` for 3 cycles at `sel`=4 -> `valid`=0 and `sel` holds at 4 during the stall. The frame completes 3 cycles late and the bit order is unchanged.
- Ignored start: pulse `start` at `sel`=3 with a different `in` -> the current word is unaffected and no second frame follows `done`.
- Mid-frame reset: assert `rst` at `sel`=5 -> outputs 0 the next cycle and no `done`. A subsequent `start` begins cleanly at `sel`=0.

Source files
------------

// File: rtl/mux81_tdm.sv
// Time-division 8:1 multiplexer/serializer: captures a parallel byte and
// emits it LSB first, one bit per cycle, with the slot index on sel.
module mux81_tdm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       start,
  input  logic       cont,
  input  logic       en,
  output logic       out,
  output logic [2:0] sel,
  output logic       valid,
  output logic       frame,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] slot_q, slot_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      slot_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // valid is registered so a stalled cycle shows valid=0 without any
  // combinational path from en to the outputs.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    slot_d   = slot_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shadow_d = in;
            slot_d   = '0;
            state_d  = SCAN;
            valid_d  = 1'b1;
          end
        end
        SCAN: begin
          if (slot_q != 3'd7) begin
            slot_d  = slot_q + 3'd1;
            valid_d = 1'b1;
          end else if (cont) begin
            shadow_d = in;
            slot_d   = '0;
            valid_d  = 1'b1;
          end else begin
            slot_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sel   = slot_q;
    out   = (state_q == SCAN) ? shadow_q[slot_q] : 1'b0;
    valid = valid_q;
    frame = valid_q && (slot_q == 3'd0);
    busy  = (state_q == SCAN);
    done  = done_q;
  end

endmodule

// File: tb/tb_mux81_tdm.sv
// Self-checking bench for mux81_tdm: directed scenarios plus a randomized run
// against a frame-level reference model.
module tb_mux81_tdm;

  logic       clk = 1'b0;
  logic       rst, start, cont, en;
  logic [7:0] in;
  logic       out, valid, frame, busy, done;
  logic [2:0] sel;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: the word being sent, which slot is on the line,
  // and whether a frame is in flight.
  bit         m_act;
  bit   [7:0] m_word;
  int         m_pos;
  bit         m_valid, m_done;

  mux81_tdm dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .start(start),
    .cont (cont),
    .en   (en),
    .out  (out),
    .sel  (sel),
    .valid(valid),
    .frame(frame),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_word = 0; m_pos = 0; m_valid = 0; m_done = 0;
    end else if (!en) begin
      m_valid = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        m_valid = start;
        if (start) begin m_act = 1; m_word = in; m_pos = 0; end
      end else if (m_pos < 7) begin
        m_pos++; m_valid = 1;
      end else if (cont) begin
        m_word = in; m_pos = 0; m_valid = 1;
      end else begin
        m_act = 0; m_pos = 0; m_valid = 0; m_done = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic c, input logic e, input logic [7:0] d);
    rst = r; start = s; cont = c; en = e; in = d;
    @(posedge clk);
    model_edge();
    #1;
    check("m_out",   32'(out),   m_act ? 32'((m_word >> m_pos) & 8'd1) : 32'd0);
    check("m_sel",   32'(sel),   32'(m_pos));
    check("m_valid", 32'(valid), 32'(m_valid));
    check("m_frame", 32'(frame), 32'(m_valid && m_pos == 0));
    check("m_busy",  32'(busy),  32'(m_act));
    check("m_done",  32'(done),  32'(m_done));
  endtask

  // Sends one word, reconstructing it the way the far-end demux would.
  task automatic send_word(input logic [7:0] w, input int stall_at, input int stall_len,
                           input int ign_at, output logic [7:0] recon, output int ncyc);
    int left = stall_len;
    recon = '0;
    ncyc  = 0;
    cyc(0, 1, 0, 1, w);
    while (!done && ncyc < 40) begin
      if (valid) recon[sel] = out;
      if (left > 0 && int'(sel) == stall_at && (valid || left < stall_len)) begin
        cyc(0, 0, 0, 0, $urandom);
        left--;
        check("stall_valid", 32'(valid), 32'd0);
        check("stall_sel",   32'(sel),   32'(stall_at));
      end else begin
        cyc(0, valid && int'(sel) == ign_at, 0, 1, ~w);
      end
      ncyc++;
    end
    check("frame_end_done", 32'(done), 32'd1);
    check("frame_len", 32'(ncyc), 32'(8 + stall_len));
  endtask

  initial begin
    logic [7:0] rec, a5, patt [4];
    int n;
    a5 = 8'hA5;
    patt[0] = 8'h00; patt[1] = 8'hFF; patt[2] = 8'h01; patt[3] = 8'h80;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) cyc(1, $urandom, $urandom, $urandom, $urandom);
    check("rst_outputs", {26'd0, out, sel, valid, frame, busy, done}, 32'd0);

    // A5 bit order.
    cyc(0, 1, 0, 1, a5);
    for (int k = 0; k < 8; k++) begin
      check("a5_out",   32'(out),   32'(a5[k]));
      check("a5_sel",   32'(sel),   32'(k));
      check("a5_valid", 32'(valid), 32'd1);
      cyc(0, 0, 0, 1, 8'h00);
    end
    check("a5_done", 32'(done), 32'd1);
    check("a5_idle", 32'(busy), 32'd0);
    cyc(0, 0, 0, 1, 8'h00);
    check("a5_done_pulse", 32'(done), 32'd0);

    // Demux loopback.
    for (int i = 0; i < 4; i++) begin
      send_word(patt[i], -1, 0, -1, rec, n);
      check("loopback", 32'(rec), 32'(patt[i]));
    end

    // Continuous mode: in changes mid-frame, captured only at slot 7.
    cyc(0, 1, 1, 1, 8'h3C);
    rec = '0;
    for (int k = 0; k < 8; k++) begin
      rec[sel] = out;
      cyc(0, 0, 1, 1, (k >= 3) ? 8'hC3 : 8'h3C);
    end
    check("cont_word1", 32'(rec), 32'h3C);
    check("cont_frame", 32'(frame), 32'd1);
    check("cont_nodone", 32'(done), 32'd0);
    rec = '0;
    for (int k = 0; k < 8; k++) begin
      check("cont_valid", 32'(valid), 32'd1);
      rec[sel] = out;
      cyc(0, 0, 0, 1, 8'h00);
    end
    check("cont_word2", 32'(rec), 32'hC3);
    check("cont_done", 32'(done), 32'd1);
    cyc(0, 0, 0, 1, 8'h00);

    // Stall of 3 cycles at sel=4.
    send_word(8'h6D, 4, 3, -1, rec, n);
    check("stall_word", 32'(rec), 32'h6D);

    // Start during SCAN is ignored and not queued.
    send_word(8'h5A, -1, 0, 3, rec, n);
    check("ign_word", 32'(rec), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      check("ign_noframe", 32'(busy), 32'd0);
    end

    // Mid-frame reset at sel=5.
    cyc(0, 1, 0, 1, 8'hFF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'hFF);
    check("mrst_sel5", 32'(sel), 32'd5);
    cyc(1, 0, 0, 1, 8'hFF);
    check("mrst_outputs", {26'd0, out, sel, valid, frame, busy, done}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      check("mrst_nodone", 32'(done), 32'd0);
    end
    cyc(0, 1, 0, 1, 8'h96);
    check("mrst_restart", {29'd0, sel}, 32'd0);
    check("mrst_frame", 32'(frame), 32'd1);
    check("mrst_out", 32'(out), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
          ($urandom_range(7) != 0), 8'($urandom));
      checks++;
      if (done && frame) begin
        errors++;
        $display("FAIL done_frame_excl: got done=1 frame=1 required not both at %0t", $time);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
